// File: rtl/r7_uart_monitor.sv
// r7_uart_monitor
//   Watches the CPU core's r7_data output. Whenever the value changes, the
//   new value goes out on a UART line as four uppercase hex characters and
//   then CR LF (8N1, LSB first, idle high). A single-entry overwrite buffer
//   holds the newest value that arrives while a message is in flight.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Ports
//   clock    in   system clock, rising edge
//   reset    in   asynchronous, active-high reset
//   r7_data  in   [15:0] value to monitor
//   tx       out  UART serial out, idle high
//   busy     out  high while a message is being transmitted
//   overrun  out  sticky: a pending value was overwritten before it was sent
module r7_uart_monitor #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] r7_data,
  output logic        tx,
  output logic        busy,
  output logic        overrun
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_BYTE = 3'd5;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [15:0]       last_seen;
  logic [15:0]       snap;
  logic [15:0]       pending;
  logic              pending_valid;
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [2:0]        byte_idx;
  logic [7:0]        cur_byte;

  logic change;
  logic baud_end;
  logic msg_done;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    // 'A' - 10 = 0x37
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Byte currently on the wire, selected from the snapshot.
  always_comb begin
    cur_byte = 8'h0A;
    case (byte_idx)
      3'd0:    cur_byte = hex_char(snap[15:12]);
      3'd1:    cur_byte = hex_char(snap[11:8]);
      3'd2:    cur_byte = hex_char(snap[7:4]);
      3'd3:    cur_byte = hex_char(snap[3:0]);
      3'd4:    cur_byte = 8'h0D;
      default: cur_byte = 8'h0A;
    endcase
  end

  assign change   = (r7_data != last_seen);
  assign baud_end = (baud_cnt == BAUD_LAST);
  // Last cycle of the final stop bit: the edge where the next message is chosen.
  assign msg_done = (state == STOP) && baud_end && (byte_idx == LAST_BYTE);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      last_seen     <= 16'h0000;
      snap          <= 16'h0000;
      pending       <= 16'h0000;
      pending_valid <= 1'b0;
      baud_cnt      <= '0;
      bit_idx       <= 3'd0;
      byte_idx      <= 3'd0;
      tx            <= 1'b1;
      busy          <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      last_seen <= r7_data;

      case (state)
        IDLE: begin
          // Start bit goes out on the same edge that sees the change.
          if (change) begin
            snap     <= r7_data;
            byte_idx <= 3'd0;
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (baud_end) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        DATA: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        STOP: begin
          if (baud_end) begin
            baud_cnt <= '0;
            if (byte_idx != LAST_BYTE) begin
              byte_idx <= byte_idx + 3'd1;
              tx       <= 1'b0;
              state    <= START;
            end else if (change) begin
              // A change seen on the completion edge is newer than anything
              // buffered, so it goes straight out and the buffer is dropped.
              snap          <= r7_data;
              byte_idx      <= 3'd0;
              tx            <= 1'b0;
              state         <= START;
              pending_valid <= 1'b0;
              if (pending_valid) overrun <= 1'b1;
            end else if (pending_valid) begin
              snap          <= pending;
              pending_valid <= 1'b0;
              byte_idx      <= 3'd0;
              tx            <= 1'b0;
              state         <= START;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase

      // Changes during a message land in the overwrite buffer; newest wins.
      if ((state != IDLE) && change && !msg_done) begin
        pending       <= r7_data;
        pending_valid <= 1'b1;
        if (pending_valid) overrun <= 1'b1;
      end
    end
  end

endmodule
